// File: rtl/dds_multi_ch_if.sv
// Register-write and sample-output bundle for dds_multi_ch.
// The master drives register writes and strobes; the slave returns samples and wrap pulses.
interface dds_multi_ch_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 10
);
    logic                     wr_en;
    logic [5:0]               wr_addr;
    logic [31:0]              wr_data;
    logic                     update;
    logic                     phase_sync;
    logic [N_CH*DATA_W-1:0]   dds_data_out;
    logic [N_CH-1:0]          wrap;

    modport master (
        output wr_en, wr_addr, wr_data, update, phase_sync,
        input  dds_data_out, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, update, phase_sync,
        output dds_data_out, wrap
    );
endinterface

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS: per-channel shadow/active settings, phase accumulator,
// phase register and waveform output register (2-cycle acc-to-output latency).
module dds_ch #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 10,
    parameter int DATA_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        wr_sel,
    input  logic [31:0]       wr_data,
    input  logic              update,
    input  logic              phase_sync,
    output logic [DATA_W-1:0] data_out,
    output logic              wrap
);
    localparam int QW = PHASE_W - 2;
    localparam int Q  = 1 << QW;
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);
    localparam logic [DATA_W-2:0] AMP = '1;

    typedef struct packed {
        logic               en;
        logic [1:0]         mode;
        logic [PHASE_W-1:0] pow;
        logic [ACC_W-1:0]   ftw;
    } cfg_t;
    localparam cfg_t CFG_RST = '{en: 1'b1, mode: 2'd0, pow: '0, ftw: '0};

    // Integer Taylor series in Q30 so the table is a pure elaboration-time constant.
    function automatic longint sine_amp(input longint idx);
        longint fx, fx2, fterm, facc;
        fx    = (64'sd1686629713 * idx) / longint'(Q);
        fx2   = (fx * fx) >>> 30;
        fterm = fx;
        facc  = fx;
        for (int k = 1; k <= 6; k++) begin
            fterm = -(((fterm * fx2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            facc  = facc + fterm;
        end
        return (longint'(AMP) * facc + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic [DATA_W-2:0] sin_lut [Q];
    for (genvar gi = 0; gi < Q; gi++) begin : g_lut
        localparam logic [DATA_W-2:0] V = (DATA_W-1)'(sine_amp(gi));
        assign sin_lut[gi] = V;
    end

    cfg_t               sh_q, sh_d, act_q, act_d, cfg_wr;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic               carry, wrap_q, wrap_d;
    logic [PHASE_W-1:0] p_q, p_d, tri_v;
    logic [PHASE_W-2:0] tri_f;
    logic [1:0]         mode_q, mode_d;
    logic               en_q, en_d;
    logic [DATA_W-1:0]  out_q, out_d, wave;
    logic [QW-1:0]      q, lut_idx;
    logic [DATA_W-2:0]  amp;

    always_comb begin
        cfg_wr = sh_q;
        if (wr_sel[0]) cfg_wr.ftw = wr_data[ACC_W-1:0];
        if (wr_sel[1]) cfg_wr.pow = wr_data[PHASE_W-1:0];
        if (wr_sel[2]) {cfg_wr.en, cfg_wr.mode} = wr_data[2:0];
        sh_d  = cfg_wr;
        // Same-cycle write and update lands in the active copy too.
        act_d = update ? cfg_wr : act_q;

        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, act_q.ftw};
        acc_d  = acc_sum;
        wrap_d = carry;
        if (phase_sync || !act_q.en) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end

        p_d    = acc_q[ACC_W-1 -: PHASE_W] + act_q.pow;
        mode_d = act_q.mode;
        en_d   = act_q.en;

        // Odd quadrants read the table mirrored; q==0 there is the exact peak.
        q       = p_q[QW-1:0];
        lut_idx = QW'(0) - q;
        amp     = p_q[QW] ? ((q == '0) ? AMP : sin_lut[lut_idx]) : sin_lut[q];
        wave    = p_q[PHASE_W-1] ? MID - DATA_W'(amp) : MID + DATA_W'(amp);
        tri_f   = p_q[PHASE_W-1] ? ~p_q[PHASE_W-2:0] : p_q[PHASE_W-2:0];
        tri_v   = {tri_f, 1'b0};

        out_d = wave;
        case (mode_q)
            2'd1:    out_d = p_q[PHASE_W-1] ? '0 : '1;
            2'd2:    out_d = p_q[PHASE_W-1 -: DATA_W];
            2'd3:    out_d = tri_v[PHASE_W-1 -: DATA_W];
            default: out_d = wave;
        endcase
        if (!en_q) out_d = MID;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_q   <= CFG_RST;
            act_q  <= CFG_RST;
            acc_q  <= '0;
            wrap_q <= 1'b0;
            p_q    <= '0;
            mode_q <= 2'd0;
            en_q   <= 1'b1;
            out_q  <= MID;
        end else begin
            sh_q   <= sh_d;
            act_q  <= act_d;
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
            p_q    <= p_d;
            mode_q <= mode_d;
            en_q   <= en_d;
            out_q  <= out_d;
        end
    end

    assign data_out = out_q;
    assign wrap     = wrap_q;
endmodule

module dds_multi_ch #(
    parameter int N_CH    = 3,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 10,
    parameter int DATA_W  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    dds_multi_ch_if.slave bus
);
    logic [N_CH-1:0][DATA_W-1:0] lane_data;
    logic [N_CH-1:0]             lane_wrap;
    logic [1:0]                  reg_sel;

    assign reg_sel = bus.wr_addr[1:0];

    // Channels >= N_CH never match; reg_sel 3 selects nothing.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic       hit;
        logic [2:0] wr_sel;
        assign hit    = bus.wr_en && (bus.wr_addr[5:2] == 4'(c));
        assign wr_sel = {hit && (reg_sel == 2'd2), hit && (reg_sel == 2'd1), hit && (reg_sel == 2'd0)};

        dds_ch #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_sel     (wr_sel),
            .wr_data    (bus.wr_data),
            .update     (bus.update),
            .phase_sync (bus.phase_sync),
            .data_out   (lane_data[c]),
            .wrap       (lane_wrap[c])
        );
    end

    assign bus.dds_data_out = lane_data;
    assign bus.wrap         = lane_wrap;
endmodule

// File: tb/tb_dds_multi_ch.sv
// Directed bench for dds_multi_ch (3 channels, 32/10/10) with hand-computed expectations.
module tb_dds_multi_ch;
    localparam int N_CH = 3, ACC_W = 32, PHASE_W = 10, DATA_W = 10;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0, n_fail = 0;
    int   bad, nz, cnt, lo, hi;
    logic [31:0] v;

    dds_multi_ch_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    dds_multi_ch #(.N_CH(N_CH), .ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input int i);
        return 32'(bus.dds_data_out[i*DATA_W +: DATA_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic upd, input logic sync);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        bus.update = upd; bus.phase_sync = sync;
        tick();
        bus.wr_en = 1'b0; bus.update = 1'b0; bus.phase_sync = 1'b0;
    endtask

    task automatic pulse(input logic upd, input logic sync);
        bus.update = upd; bus.phase_sync = sync;
        tick();
        bus.update = 1'b0; bus.phase_sync = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.update = 1'b0; bus.phase_sync = 1'b0;
        tick(); tick();
        for (int c = 0; c < N_CH; c++) chk("rst_lane", lane(c), 512);
        chk("rst_wrap", 32'(bus.wrap), 0);
        reset_n = 1'b1;
        repeat (5) tick();
        for (int c = 0; c < N_CH; c++) chk("idle_lane", lane(c), 512);

        // ch0 POW with write-through; upper data bits ignored (0x500 -> 256)
        wr(6'd1, 32'h500, 1'b1, 1'b0);
        tick(); chk("wt_old", lane(0), 512);
        tick(); chk("pow256", lane(0), 1023);
        wr(6'd1, 32'd768, 1'b0, 1'b0);
        bad = 0;
        repeat (100) begin tick(); if (lane(0) != 1023) bad++; end
        chk("shadow_hold", bad, 0);
        pulse(1'b1, 1'b0);
        tick(); tick(); chk("pow768", lane(0), 1);
        wr(6'd1, 32'd1, 1'b1, 1'b0);
        tick(); chk("wt_old2", lane(0), 1);
        tick(); chk("pow1", lane(0), 515);
        wr(6'd1, 32'd1023, 1'b1, 1'b0); tick(); tick(); chk("pow1023", lane(0), 509);
        wr(6'd1, 32'd128, 1'b1, 1'b0);  tick(); tick(); chk("pow128", lane(0), 873);
        wr(6'd1, 32'd0, 1'b1, 1'b0);    tick(); tick(); chk("pow0", lane(0), 512);

        // ch1 FTW=85899: first wrap after 50001 adds, full sine span
        wr(6'd4, 32'd85899, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        cnt = 0; lo = 1023; hi = 0; bad = 0;
        for (int j = 1; j <= 60000; j++) begin
            tick();
            v = lane(1);
            if (int'(v) < lo) lo = int'(v);
            if (int'(v) > hi) hi = int'(v);
            if (lane(0) != 512 || lane(2) != 512 || bus.wrap[0] || bus.wrap[2]) bad++;
            if (bus.wrap[1]) begin cnt = j; break; end
        end
        chk("wrap_first", cnt, 50001);
        tick(); chk("wrap_width", 32'(bus.wrap[1]), 0);
        chk("span_lo", lo, 1);
        chk("span_hi", hi, 1023);
        chk("others_idle", bad, 0);

        // ch2 half a period ahead of ch1 after coherent update + sync
        wr(6'd8, 32'd85899, 1'b0, 1'b0);
        wr(6'd9, 32'd512, 1'b0, 1'b0);
        pulse(1'b1, 1'b1);
        tick();
        tick(); chk("sync_lane1", lane(1), 512);
        bad = 0; nz = 0;
        for (int j = 0; j < 3000; j++) begin
            tick();
            if (lane(2) != 32'd1024 - lane(1)) bad++;
            if (lane(1) != 512) nz++;
        end
        chk("antiphase", bad, 0);
        chk("antiphase_moving", (nz > 0) ? 1 : 0, 1);

        // ch0 FTW=2^22: one phase step per cycle
        wr(6'd0, 32'h0040_0000, 1'b0, 1'b0);
        wr(6'd2, 32'd5, 1'b1, 1'b1);
        for (int j = 1; j <= 1025; j++) begin
            tick();
            if (j >= 2) chk("square", lane(0), ((j - 2) < 512) ? 1023 : 0);
            chk("sq_wrap", 32'(bus.wrap[0]), (j == 1024) ? 1 : 0);
        end
        wr(6'd2, 32'd6, 1'b1, 1'b1);
        for (int j = 1; j <= 1025; j++) begin
            tick();
            if (j >= 2) chk("saw", lane(0), j - 2);
        end
        wr(6'd2, 32'd7, 1'b1, 1'b1);
        for (int j = 1; j <= 1025; j++) begin
            tick();
            if (j >= 2) chk("triangle", lane(0), ((j - 2) < 512) ? 2 * (j - 2) : 2 * (1023 - (j - 2)));
        end

        // disable ch0
        wr(6'd2, 32'd2, 1'b1, 1'b0);
        tick(); chk("dis_wrap", 32'(bus.wrap[0]), 0);
        tick(); chk("dis_mid", lane(0), 512);
        bad = 0;
        repeat (1100) begin tick(); if (lane(0) != 512 || bus.wrap[0]) bad++; end
        chk("dis_hold", bad, 0);

        // pending shadow write lost at reset; ch3/ch15 and reg_sel 3 ignored
        wr(6'd2, 32'd6, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        for (int c = 0; c < N_CH; c++) chk("midrst_lane", lane(c), 512);
        chk("midrst_wrap", 32'(bus.wrap), 0);
        reset_n = 1'b1;
        wr(6'd12, 32'h0040_0000, 1'b0, 1'b0);
        wr(6'd14, 32'd6, 1'b0, 1'b0);
        wr(6'd62, 32'd6, 1'b0, 1'b0);
        wr(6'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        bad = 0;
        repeat (1100) begin
            tick();
            for (int c = 0; c < N_CH; c++) if (lane(c) != 512) bad++;
            if (bus.wrap != '0) bad++;
        end
        chk("ignored_writes", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_multi_ch.md
# dds_multi_ch

Parametrised multi-channel direct digital synthesiser. It generates N_CH independent phase-accumulator waveforms, each with its own frequency, phase offset and waveform mode, all on one clock. Channel settings are written through a simple register port into shadow registers. A single `update` strobe transfers them to the active registers on all channels at once, so frequency and phase changes are phase-coherent across channels. It feeds the modulator datapath in place of fixed-tuning carrier generators.

## Interface
- N_CH, 3: number of channels, 1..16
- ACC_W, 32: phase accumulator width, 16..32
- PHASE_W, 10: phase/address width taken from the accumulator MSBs; PHASE_W ≥ DATA_W+1 is not required, PHASE_W ≥ DATA_W is
- DATA_W, 10: output sample width, offset binary
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  register write strobe
- wr_addr  in  6  {channel[5:2], reg_sel[1:0]}
- wr_data  in  32  write data, LSB-aligned
- update  in  1  one-cycle pulse: copy all shadow registers to active
- phase_sync  in  1  one-cycle pulse: clear all accumulators
- dds_data_out  out  N_CH*DATA_W  samples, channel 0 in LSBs
- wrap  out  N_CH  one-cycle pulse per channel on accumulator overflow

## Operation
- reg_sel 0: FTW, ACC_W bits. reg_sel 1: POW, PHASE_W bits. reg_sel 2: {en[2], mode[1:0]}. reg_sel 3 is reserved; writes are ignored and have no effect.
- Writes with channel ≥ N_CH are ignored. Unused upper wr_data bits are ignored.
- Shadow and active copies exist for FTW, POW, mode and en. Writes touch only the shadow copy.
- `update` loads every active register from its shadow copy. If `wr_en` and `update` occur in the same cycle, the written value goes to the shadow register and also to the active register (write-through).
- Accumulator, per enabled channel: acc <= acc + FTW_active, mod 2^ACC_W. `wrap` is the registered carry-out of this add.
- Phase: p <= acc[ACC_W-1 -: PHASE_W] + POW_active, mod 2^PHASE_W.
- Mode 0, sine: quarter-wave LUT of 2^(PHASE_W-2) entries, computed at elaboration.
  - Full wave = round((2^(DATA_W-1)-1)·sin(2πp/2^PHASE_W)) + 2^(DATA_W-1).
  - Quadrant folding must be exact: the value at p and at 2^PHASE_W−p must sum to 2^DATA_W for p ≠ 0.
- Mode 1, square: p MSB = 0 → 2^DATA_W−1; p MSB = 1 → 0.
- Mode 2, sawtooth: p[PHASE_W-1 -: DATA_W].
- Mode 3, triangle: f = p MSB ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0]. Output = top DATA_W bits of {f,1'b0}.
- Disabled channel (en = 0): acc held at 0, no wrap pulse, output forced to midscale 2^(DATA_W-1).
- `phase_sync`: all accumulators are set to 0 at that edge and the add is skipped. It takes priority over accumulation. If it coincides with `update`, the accumulators are 0 after the edge and add the new FTW from the next edge on.

## Timing
- Pipeline: acc (edge n) → p register (edge n+1) → output register (edge n+2). Fixed latency of 2 cycles from accumulator to dds_data_out.
- `update` at edge k: the active registers change at edge k. The new FTW is first added at edge k+1. The new POW/mode/en is first visible at dds_data_out at edge k+2.
- `phase_sync` at edge k: dds_data_out equals the waveform at phase POW_active at edge k+2.
- `wrap` asserts in the cycle after the overflowing add, one cycle wide, aligned with acc stage.
- Reset values:
  - acc 0; p 0.
  - All shadow and active FTW 0, POW 0, mode 0, en 1.
  - wrap 0; every dds_data_out lane 2^(DATA_W-1) (midscale, sine at phase 0).
- Reset asserted mid-operation returns every register to its reset value at that edge. Pending shadow writes are lost.

## Test plan
- Reset, defaults (N_CH=3, 32/10/10): all lanes read 512, wrap=0, and they stay constant with FTW=0.
- Write FTW=85899 to ch1, then pulse update: ch1 wrap period is 50000 cycles ±1, and ch1 samples span 1..1023 with midscale at 512. ch0 and ch2 stay at 512.
- Write FTW=85899 to ch1 and ch2, POW=512 to ch2, then update with a simultaneous phase_sync: lane2 = 1024 − lane1 on every cycle (lane1 ≠ 512).
- Write to ch1 without update: no output change for 100 cycles. Write to ch1 in the same cycle as update: the change is visible per write-through timing.
- Set FTW=2^22 and step modes 1/2/3 on ch0: square gives 1023×512 cycles then 0×512. Saw ramps 0..1023 by 1. Triangle runs 0,2,…,1022,1022,…,0.
- Set en=0 with update: output is 512 after 2 cycles and wrap stays 0. Assert reset_n low mid-run: all outputs are 512 the following cycle, and a write to channel 3 and to reg_sel 3 is ignored.
